// File: rtl/lzw_pkg.sv
// Shared constants, types and the dictionary hash for the LZW compressor.
package lzw_pkg;

  localparam int CODE_W       = 12;
  localparam int CHAR_W       = 8;
  localparam int DICT_ENTRIES = 4096;

  localparam logic [12:0] DICT_DEPTH = 13'd4096;
  localparam logic [12:0] FIRST_CODE = 13'd256;
  localparam logic [12:0] MAX_BYTES  = 13'd4096;
  localparam logic [7:0]  EOF_CODE   = 8'h0D;
  localparam logic [11:0] LAST_ADDR  = 12'hFFF;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_WAIT   = 3'd1,
    S_LOOKUP = 3'd2,
    S_CMP    = 3'd3,
    S_FLUSH  = 3'd4,
    S_FIN    = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [CODE_W-1:0] prefix;
    logic [CHAR_W-1:0] ch;
    logic [CODE_W-1:0] code;
  } dict_entry_t;

  // Dictionary slot for a (prefix, char) pair; collisions simply overwrite.
  function automatic logic [CODE_W-1:0] lzw_hash(input logic [CODE_W-1:0] p,
                                                 input logic [CHAR_W-1:0] c);
    return p ^ {c, 4'b0000};
  endfunction

endpackage

// File: rtl/lzw_dict_ram.sv
// Single-port dictionary RAM, synchronous read with one cycle of latency.
module lzw_dict_ram
  import lzw_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [CODE_W-1:0] addr,
  input  dict_entry_t       wdata,
  output dict_entry_t       rdata
);

  dict_entry_t mem [0:DICT_ENTRIES-1];

  // Write when enabled; always register the addressed entry for the next cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/lzw_system.sv
// LZW compressor core: clears the dictionary, then encodes one byte packet
// into 12-bit codes and flushes the final prefix at end of packet.
module lzw_system
  import lzw_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [CHAR_W-1:0] in_data,
  output logic              in_ready,
  output logic              code_valid,
  output logic [CODE_W-1:0] code_out,
  output logic              init_cr,
  output logic              done_cr,
  output logic              lzw_done,
  output logic              final_done
);

  state_t            state, state_n;
  logic [CODE_W-1:0] clr_addr, clr_addr_n;
  logic [12:0]       next_code, next_code_n;
  logic [12:0]       byte_cnt, byte_cnt_n;
  logic [CODE_W-1:0] prefix, prefix_n;
  logic [CHAR_W-1:0] cur_char, cur_char_n;
  logic              has_prefix, has_prefix_n;
  logic              end_pending, end_pending_n;
  logic              in_ready_n, code_valid_n, init_cr_n, done_cr_n;
  logic              lzw_done_n, final_done_n;
  logic [CODE_W-1:0] code_out_n;

  logic              ram_we;
  logic [CODE_W-1:0] ram_addr;
  dict_entry_t       ram_wdata, ram_rdata;
  logic              hit;

  lzw_dict_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign hit = ram_rdata.valid && (ram_rdata.prefix == prefix) && (ram_rdata.ch == cur_char);

  // Next-state, RAM control and next values for every register.
  always_comb begin
    state_n       = state;
    clr_addr_n    = clr_addr;
    next_code_n   = next_code;
    byte_cnt_n    = byte_cnt;
    prefix_n      = prefix;
    cur_char_n    = cur_char;
    has_prefix_n  = has_prefix;
    end_pending_n = end_pending;
    code_valid_n  = 1'b0;
    code_out_n    = code_out;
    init_cr_n     = init_cr;
    done_cr_n     = done_cr;
    lzw_done_n    = lzw_done;
    final_done_n  = final_done;
    ram_we        = 1'b0;
    ram_addr      = lzw_hash(prefix, cur_char);
    ram_wdata     = '0;

    case (state)
      S_INIT: begin
        ram_addr = clr_addr;
        // First cycle after reset only raises init_cr; clearing follows.
        if (!init_cr) begin
          init_cr_n = 1'b1;
        end else begin
          ram_we     = 1'b1;
          clr_addr_n = clr_addr + 12'd1;
          if (clr_addr == LAST_ADDR) begin
            init_cr_n = 1'b0;
            done_cr_n = 1'b1;
            state_n   = S_WAIT;
          end else begin
            state_n = S_INIT;
          end
        end
      end
      S_WAIT: begin
        if (in_valid && in_ready) begin
          if (in_data == EOF_CODE) begin
            lzw_done_n = 1'b1;
            state_n    = S_FLUSH;
          end else begin
            byte_cnt_n = byte_cnt + 13'd1;
            if (!has_prefix) begin
              prefix_n     = {4'h0, in_data};
              has_prefix_n = 1'b1;
              if (byte_cnt + 13'd1 == MAX_BYTES) begin
                lzw_done_n = 1'b1;
                state_n    = S_FLUSH;
              end else begin
                state_n = S_WAIT;
              end
            end else begin
              cur_char_n    = in_data;
              end_pending_n = (byte_cnt + 13'd1 == MAX_BYTES);
              state_n       = S_LOOKUP;
            end
          end
        end else begin
          state_n = S_WAIT;
        end
      end
      S_LOOKUP: begin
        state_n = S_CMP;
      end
      S_CMP: begin
        if (hit) begin
          prefix_n = ram_rdata.code;
        end else begin
          code_valid_n = 1'b1;
          code_out_n   = prefix;
          // A full dictionary still emits the code but stops learning.
          if (next_code < DICT_DEPTH) begin
            ram_we      = 1'b1;
            ram_wdata   = '{valid: 1'b1, prefix: prefix, ch: cur_char,
                            code: next_code[CODE_W-1:0]};
            next_code_n = next_code + 13'd1;
          end else begin
            ram_we = 1'b0;
          end
          prefix_n = {4'h0, cur_char};
        end
        if (end_pending) begin
          end_pending_n = 1'b0;
          lzw_done_n    = 1'b1;
          state_n       = S_FLUSH;
        end else begin
          state_n = S_WAIT;
        end
      end
      S_FLUSH: begin
        if (has_prefix) begin
          code_valid_n = 1'b1;
          code_out_n   = prefix;
          state_n      = S_FIN;
        end else begin
          final_done_n = 1'b1;
          state_n      = S_DONE;
        end
      end
      S_FIN: begin
        final_done_n = 1'b1;
        state_n      = S_DONE;
      end
      S_DONE: begin
        state_n = S_DONE;
      end
      default: begin
        state_n = S_INIT;
      end
    endcase

    in_ready_n = (state_n == S_WAIT);
  end

  // State and datapath registers; every output is driven from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_INIT;
      clr_addr    <= 12'd0;
      next_code   <= FIRST_CODE;
      byte_cnt    <= 13'd0;
      prefix      <= 12'd0;
      cur_char    <= 8'd0;
      has_prefix  <= 1'b0;
      end_pending <= 1'b0;
      in_ready    <= 1'b0;
      code_valid  <= 1'b0;
      code_out    <= 12'd0;
      init_cr     <= 1'b0;
      done_cr     <= 1'b0;
      lzw_done    <= 1'b0;
      final_done  <= 1'b0;
    end else begin
      state       <= state_n;
      clr_addr    <= clr_addr_n;
      next_code   <= next_code_n;
      byte_cnt    <= byte_cnt_n;
      prefix      <= prefix_n;
      cur_char    <= cur_char_n;
      has_prefix  <= has_prefix_n;
      end_pending <= end_pending_n;
      in_ready    <= in_ready_n;
      code_valid  <= code_valid_n;
      code_out    <= code_out_n;
      init_cr     <= init_cr_n;
      done_cr     <= done_cr_n;
      lzw_done    <= lzw_done_n;
      final_done  <= final_done_n;
    end
  end

endmodule

// File: tb/tb_lzw_system.sv
// Scoreboard bench for lzw_system: a reference LZW model fills the expected
// code queue per packet; a negedge monitor pops and compares emitted codes.
module tb_lzw_system;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, code_valid, init_cr, done_cr, lzw_done, final_done;
  logic [11:0] code_out;

  lzw_system dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .code_valid (code_valid),
    .code_out   (code_out),
    .init_cr    (init_cr),
    .done_cr    (done_cr),
    .lzw_done   (lzw_done),
    .final_done (final_done)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          n_codes = 0;
  int          ld_cyc = 0;
  int          fd_cyc = 0;
  int          last_code_cyc = 0;
  bit          ld_seen = 1'b0;
  bit          fd_seen = 1'b0;
  bit          sb_en = 1'b0;
  logic [11:0] first_code = 12'h000;
  logic [11:0] exp_q [$];
  logic [7:0]  pkt [$];

  // reference dictionary
  logic        m_valid [4096];
  logic [11:0] m_pre   [4096];
  logic [7:0]  m_ch    [4096];
  logic [11:0] m_code  [4096];

  // cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // output monitor and scoreboard
  always @(negedge clk) begin
    logic [11:0] e;
    if (rst) begin
      n_codes = 0;
      ld_seen = 1'b0;
      fd_seen = 1'b0;
    end else begin
      if (code_valid) begin
        if (n_codes == 0) first_code = code_out;
        n_codes++;
        last_code_cyc = cyc;
        if (sb_en) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_extra_code got=%h expected=none", code_out);
          end else begin
            e = exp_q.pop_front();
            if (code_out !== e) begin
              bad++;
              $display("FAIL sb_code got=%h expected=%h", code_out, e);
            end
          end
        end
      end
      if (lzw_done && !ld_seen) begin ld_seen = 1'b1; ld_cyc = cyc; end
      if (final_done && !fd_seen) begin fd_seen = 1'b1; fd_cyc = cyc; end
    end
  end

  task automatic model_run();
    int          nc;
    int          cnt;
    bit          hp;
    logic [11:0] p;
    logic [11:0] h;
    logic [7:0]  b;
    for (int i = 0; i < 4096; i++) m_valid[i] = 1'b0;
    nc = 256; cnt = 0; hp = 1'b0; p = 12'h000;
    for (int i = 0; i < pkt.size(); i++) begin
      b = pkt[i];
      if (b == 8'h0D) break;
      cnt++;
      if (!hp) begin
        p = {4'h0, b}; hp = 1'b1;
      end else begin
        h = p ^ {b, 4'b0000};
        if (m_valid[h] && m_pre[h] == p && m_ch[h] == b) begin
          p = m_code[h];
        end else begin
          exp_q.push_back(p);
          if (nc < 4096) begin
            m_valid[h] = 1'b1; m_pre[h] = p; m_ch[h] = b; m_code[h] = nc[11:0];
            nc++;
          end
          p = {4'h0, b};
        end
      end
      if (cnt == 4096) break;
    end
    if (hp) exp_q.push_back(p);
    sb_en = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send_timeout got=in_ready_low expected=in_ready_high");
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic count_init(output int c);
    c = 0;
    for (int n = 0; n < 6000; n++) begin
      @(negedge clk);
      if (init_cr) c++;
      if (done_cr) break;
    end
  endtask

  task automatic do_reset();
    int c;
    rst = 1'b1; in_valid = 1'b0; sb_en = 1'b0; exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    count_init(c);
    total++;
    if (!done_cr) begin bad++; $display("FAIL reset_done_cr got=%b expected=1", done_cr); end
  endtask

  task automatic run_pkt();
    int n;
    model_run();
    for (int i = 0; i < pkt.size(); i++) send_byte(pkt[i]);
    n = 0;
    while (!final_done && n < 20000) begin @(negedge clk); n++; end
    total++;
    if (!final_done) begin bad++; $display("FAIL final_done_timeout got=0 expected=1"); end
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL sb_missing got=%0d_left expected=0", exp_q.size()); end
  endtask

  task automatic test_reset();
    int c;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({init_cr, done_cr, in_ready, code_valid, lzw_done, final_done, code_out} !== 18'h0) begin
      bad++; $display("FAIL reset_outputs got=%b expected=0",
                      {init_cr, done_cr, in_ready, code_valid, lzw_done, final_done, code_out});
    end
    rst = 1'b0;
    count_init(c);
    total++;
    if (c != 4096) begin bad++; $display("FAIL init_cycles got=%0d expected=4096", c); end
    total++;
    if (done_cr !== 1'b1 || init_cr !== 1'b0) begin
      bad++; $display("FAIL init_end got=%b%b expected=01", init_cr, done_cr);
    end
    repeat (20) @(negedge clk);
    total++;
    if (n_codes != 0) begin bad++; $display("FAIL idle_codes got=%0d expected=0", n_codes); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b expected=1", in_ready); end
  endtask

  task automatic test_max_bytes();
    do_reset();
    pkt.delete();
    repeat (4096) pkt.push_back(8'h63);
    run_pkt();
    total++;
    if (n_codes != 91) begin bad++; $display("FAIL max_count got=%0d expected=91", n_codes); end
    total++;
    if (first_code !== 12'h063) begin bad++; $display("FAIL max_first got=%h expected=063", first_code); end
    total++;
    if (!ld_seen || ld_cyc >= fd_cyc) begin
      bad++; $display("FAIL max_lzw_done got=%0d/%0d expected=before_final %0d", ld_seen, ld_cyc, fd_cyc);
    end
    total++;
    if (fd_cyc != last_code_cyc + 1) begin
      bad++; $display("FAIL max_final_timing got=%0d expected=%0d", fd_cyc, last_code_cyc + 1);
    end
  endtask

  task automatic test_abab();
    do_reset();
    pkt = '{8'h41, 8'h42, 8'h41, 8'h42, 8'h41, 8'h42, 8'h41, 8'h0D};
    run_pkt();
    total++;
    if (n_codes != 4) begin bad++; $display("FAIL abab_count got=%0d expected=4", n_codes); end
    total++;
    if (dut.next_code !== 13'h103) begin bad++; $display("FAIL abab_next_code got=%h expected=103", dut.next_code); end
    total++;
    if (fd_cyc != last_code_cyc + 1) begin
      bad++; $display("FAIL abab_final_timing got=%0d expected=%0d", fd_cyc, last_code_cyc + 1);
    end
  endtask

  task automatic test_empty();
    do_reset();
    pkt = '{8'h0D};
    run_pkt();
    total++;
    if (n_codes != 0) begin bad++; $display("FAIL empty_count got=%0d expected=0", n_codes); end
    total++;
    if (!ld_seen || fd_cyc != ld_cyc + 1) begin
      bad++; $display("FAIL empty_final_timing got=%0d expected=%0d", fd_cyc, ld_cyc + 1);
    end
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL empty_ready got=%b expected=0", in_ready); end
  endtask

  task automatic test_single();
    do_reset();
    pkt = '{8'h7A, 8'h0D};
    run_pkt();
    total++;
    if (n_codes != 1 || first_code !== 12'h07A) begin
      bad++; $display("FAIL single_code got=%0d/%h expected=1/07a", n_codes, first_code);
    end
  endtask

  task automatic test_mid_reset();
    int c;
    do_reset();
    for (int i = 0; i < 100; i++) send_byte(8'h41 + 8'(i % 5));
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({init_cr, done_cr, in_ready, code_valid, lzw_done, final_done, code_out} !== 18'h0) begin
      bad++; $display("FAIL midreset_outputs got=%b expected=0",
                      {init_cr, done_cr, in_ready, code_valid, lzw_done, final_done, code_out});
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    count_init(c);
    total++;
    if (c != 4096) begin bad++; $display("FAIL midreset_init got=%0d expected=4096", c); end
    pkt = '{8'h63, 8'h63, 8'h0D};
    run_pkt();
    total++;
    if (n_codes != 2) begin bad++; $display("FAIL midreset_count got=%0d expected=2", n_codes); end
    total++;
    if (dut.next_code !== 13'h101) begin bad++; $display("FAIL midreset_next_code got=%h expected=101", dut.next_code); end
  endtask

  initial begin
    test_reset();
    test_max_bytes();
    test_abab();
    test_empty();
    test_single();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
